maxpool_ctrl: RTL and testbench



---
 rtl/maxpool_ctrl.sv | 173 +++++++++++++++++
 tb/tb_maxpool_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: walks a row-major HxW map in 2x2 stride-2 windows, loads each
// window into the 4-lane PATCH bus, waits POOL_LAT cycles and writes RESULT to
// a row-major output map.
// Ports:
//   CLK, rst_n          clock, synchronous active-low reset
//   start               request, sampled only in IDLE
//   in_base, out_base   map base addresses, latched on start
//   busy, done          status (busy in READ..WRITE, done one-cycle pulse)
//   rd_en, rd_addr      input memory read port, rd_data one cycle later
//   PATCH               {BR, BL, TR, TL} window lanes to the pool unit
//   RESULT              pool unit output
//   wr_en, wr_addr, wr_data  output memory write port
module maxpool_ctrl #(
  parameter int unsigned DW       = 64,
  parameter int unsigned W        = 8,
  parameter int unsigned H        = 8,
  parameter int unsigned AW       = 16,
  parameter int unsigned POOL_LAT = 1
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   in_base,
  input  logic [AW-1:0]   out_base,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   rd_data,
  output logic [4*DW-1:0] PATCH,
  input  logic [DW-1:0]   RESULT,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data
);

  localparam int unsigned KMAX = (POOL_LAT > 4) ? POOL_LAT : 4;
  localparam int unsigned KW   = (KMAX > 4) ? $clog2(KMAX) : 2;
  localparam logic [KW-1:0] K_READ_LAST = KW'(3);
  localparam logic [KW-1:0] K_POOL_LAST = KW'(POOL_LAT - 1);
  // A map narrower or shorter than one window produces no output at all.
  localparam bit EMPTY_MAP = (W < 2) || (H < 2);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_FILL, S_POOL, S_WRITE, S_DONE
  } state_e;

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [AW-1:0]   r_q, c_q, o_q;
  logic [AW-1:0]   in_base_q, out_base_q;
  logic [DW-1:0]   lane_q [4];
  logic            busy_q, done_q, rd_en_q, wr_en_q;
  logic [AW-1:0]   rd_addr_q, wr_addr_q;

  // Window position after the current one (odd trailing row/column dropped).
  logic [AW-1:0] c_step, c_next, r_next;
  logic          row_wrap, last_win;

  assign c_step   = c_q + AW'(2);
  assign row_wrap = (c_step + AW'(1)) >= AW'(W);
  assign c_next   = row_wrap ? '0 : c_step;
  assign r_next   = row_wrap ? (r_q + AW'(2)) : r_q;
  assign last_win = (r_next + AW'(1)) >= AW'(H);

  // Element address of lane kk of the window at (row, col), modulo 2^AW.
  function automatic logic [AW-1:0] rd_addr_f(input logic [AW-1:0] base,
                                              input logic [AW-1:0] row,
                                              input logic [AW-1:0] col,
                                              input logic [1:0]    kk);
    rd_addr_f = base + (row + AW'(kk[1])) * AW'(W) + col + AW'(kk[0]);
  endfunction

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      o_q        <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            in_base_q  <= in_base;
            out_base_q <= out_base;
            r_q        <= '0;
            c_q        <= '0;
            o_q        <= '0;
            k_q        <= '0;
            if (EMPTY_MAP) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_READ;
              busy_q    <= 1'b1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= rd_addr_f(in_base, '0, '0, 2'd0);
            end
          end
        end
        S_READ: begin
          // Data for the address issued in phase k-1 arrives in phase k.
          if (k_q != '0) lane_q[k_q[1:0] - 2'd1] <= rd_data;
          if (k_q == K_READ_LAST) begin
            state_q <= S_FILL;
            rd_en_q <= 1'b0;
            k_q     <= '0;
          end else begin
            k_q       <= k_q + KW'(1);
            rd_addr_q <= rd_addr_f(in_base_q, r_q, c_q, k_q[1:0] + 2'd1);
          end
        end
        S_FILL: begin
          lane_q[3] <= rd_data;
          state_q   <= S_POOL;
          k_q       <= '0;
        end
        S_POOL: begin
          if (k_q == K_POOL_LAST) begin
            state_q   <= S_WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= out_base_q + o_q;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          c_q     <= c_next;
          r_q     <= r_next;
          o_q     <= o_q + AW'(1);
          k_q     <= '0;
          if (last_win) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_READ;
            rd_en_q   <= 1'b1;
            rd_addr_q <= rd_addr_f(in_base_q, r_next, c_next, 2'd0);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign PATCH   = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
  // RESULT is only valid in WRITE, so it is passed through rather than staged.
  assign wr_data = wr_en_q ? RESULT : '0;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Directed bench for maxpool_ctrl: three instances (4x4/lat1, 5x3/lat1,
// 4x2/lat3) against a memory returning mem[i]=i and a max-of-4 pool model.
module tb_maxpool_ctrl;

  logic         CLK = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  in_base = '0, out_base = '0;
  logic         a_start = 1'b0, b_start = 1'b0, k_start = 1'b0;

  logic a_busy, a_done, a_rd_en, a_wr_en;
  logic b_busy, b_done, b_rd_en, b_wr_en;
  logic k_busy, k_done, k_rd_en, k_wr_en;
  logic [15:0]  a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr, k_rd_addr, k_wr_addr;
  logic [63:0]  a_rd_data = '0, b_rd_data = '0, k_rd_data = '0;
  logic [63:0]  a_res = '0, b_res = '0, k_res = '0, k_p1 = '0, k_p2 = '0;
  logic [63:0]  a_wr_data, b_wr_data, k_wr_data;
  logic [255:0] a_patch, b_patch, k_patch;

  always #5 CLK = ~CLK;

  maxpool_ctrl #(.DW(64), .W(4), .H(4), .AW(16), .POOL_LAT(1)) dut_a (
    .CLK(CLK), .rst_n(rst_n), .start(a_start), .in_base(in_base), .out_base(out_base),
    .busy(a_busy), .done(a_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .PATCH(a_patch), .RESULT(a_res), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data));

  maxpool_ctrl #(.DW(64), .W(5), .H(3), .AW(16), .POOL_LAT(1)) dut_b (
    .CLK(CLK), .rst_n(rst_n), .start(b_start), .in_base(in_base), .out_base(out_base),
    .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .PATCH(b_patch), .RESULT(b_res), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data));

  maxpool_ctrl #(.DW(64), .W(4), .H(2), .AW(16), .POOL_LAT(3)) dut_k (
    .CLK(CLK), .rst_n(rst_n), .start(k_start), .in_base(in_base), .out_base(out_base),
    .busy(k_busy), .done(k_done), .rd_en(k_rd_en), .rd_addr(k_rd_addr),
    .rd_data(k_rd_data), .PATCH(k_patch), .RESULT(k_res), .wr_en(k_wr_en),
    .wr_addr(k_wr_addr), .wr_data(k_wr_data));

  function automatic logic [63:0] max4(input logic [255:0] p);
    logic [63:0] m;
    m = p[63:0];
    if (p[127:64]  > m) m = p[127:64];
    if (p[191:128] > m) m = p[191:128];
    if (p[255:192] > m) m = p[255:192];
    return m;
  endfunction

  // Memory (mem[i] = i, one-cycle read) and pool unit models.
  always @(posedge CLK) begin
    if (a_rd_en) a_rd_data <= {48'd0, a_rd_addr};
    if (b_rd_en) b_rd_data <= {48'd0, b_rd_addr};
    if (k_rd_en) k_rd_data <= {48'd0, k_rd_addr};
    a_res <= max4(a_patch);
    b_res <= max4(b_patch);
    k_p1  <= max4(k_patch);
    k_p2  <= k_p1;
    k_res <= k_p2;
  end

  // Observed instance selection.
  int           sel = 0;
  logic         m_busy, m_done, m_rd_en, m_wr_en;
  logic [15:0]  m_rd_addr, m_wr_addr;
  logic [63:0]  m_wr_data;
  logic [255:0] m_patch;

  always_comb begin
    m_busy = a_busy; m_done = a_done; m_rd_en = a_rd_en; m_wr_en = a_wr_en;
    m_rd_addr = a_rd_addr; m_wr_addr = a_wr_addr; m_wr_data = a_wr_data; m_patch = a_patch;
    if (sel == 1) begin
      m_busy = b_busy; m_done = b_done; m_rd_en = b_rd_en; m_wr_en = b_wr_en;
      m_rd_addr = b_rd_addr; m_wr_addr = b_wr_addr; m_wr_data = b_wr_data; m_patch = b_patch;
    end else if (sel == 2) begin
      m_busy = k_busy; m_done = k_done; m_rd_en = k_rd_en; m_wr_en = k_wr_en;
      m_rd_addr = k_rd_addr; m_wr_addr = k_wr_addr; m_wr_data = k_wr_data; m_patch = k_patch;
    end
  end

  // Cycle numbering: the start edge is cycle 0; the period after it is cycle 1.
  int edge_cnt = 0;
  int t0 = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  typedef struct { int cyc; logic [15:0] addr; logic [63:0] data; } wlog_t;
  wlog_t       wr_log[$];
  logic [15:0] rd_log[$];
  int          overlap, done_n, done_cyc, viol, mcyc;
  logic        done_busy;
  logic        mon_clr = 1'b0;

  always @(negedge CLK) begin
    if (mon_clr) begin
      wr_log.delete(); rd_log.delete();
      overlap = 0; done_n = 0; done_cyc = 0; viol = 0; done_busy = 1'b0;
    end else begin
      mcyc = edge_cnt - t0 + 1;
      if (m_rd_en) rd_log.push_back(m_rd_addr);
      if (m_rd_en && m_wr_en) overlap++;
      if (m_wr_en) wr_log.push_back('{mcyc, m_wr_addr, m_wr_data});
      if (m_done) begin done_n++; done_cyc = mcyc; done_busy = m_busy; end
      // 5x3 map: row 2 (addr >= 10) and column 4 must never be read.
      if (sel == 1 && m_rd_en && (int'(m_rd_addr) >= 10 || int'(m_rd_addr) % 5 == 4)) viol++;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " busy"},    256'(m_busy),    '0);
    chk({tag, " done"},    256'(m_done),    '0);
    chk({tag, " rd_en"},   256'(m_rd_en),   '0);
    chk({tag, " wr_en"},   256'(m_wr_en),   '0);
    chk({tag, " rd_addr"}, 256'(m_rd_addr), '0);
    chk({tag, " wr_addr"}, 256'(m_wr_addr), '0);
    chk({tag, " wr_data"}, 256'(m_wr_data), '0);
    chk({tag, " PATCH"},   m_patch,         '0);
  endtask

  task automatic drive_start(input int inst, input logic v);
    a_start = (inst == 0) && v;
    b_start = (inst == 1) && v;
    k_start = (inst == 2) && v;
  endtask

  typedef struct {
    int inst; logic [15:0] ib; logic [15:0] ob;
    int s1; int s2; int rcyc; int nwr; int done_cyc; int ndone;
  } case_t;
  typedef struct { int tc; int cyc; logic [15:0] addr; logic [63:0] data; } wexp_t;
  typedef struct { int tc; int idx; logic [15:0] addr; } rexp_t;

  case_t cases[7];
  wexp_t wexp[19];
  rexp_t rexp[8];

  // Start one run and observe it for a fixed 40-cycle window.
  task automatic run(input case_t tc);
    sel = tc.inst; in_base = tc.ib; out_base = tc.ob;
    mon_clr = 1'b1;
    @(posedge CLK); #1;
    mon_clr = 1'b0;
    drive_start(tc.inst, 1'b1);
    @(posedge CLK); #1;
    t0 = edge_cnt;
    drive_start(tc.inst, 1'b0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      drive_start(tc.inst, (cyc == tc.s1) || (cyc == tc.s2));
      if (cyc == tc.rcyc) rst_n = 1'b0;
      if (cyc == tc.rcyc + 1) begin
        rst_n = 1'b1;
        chk_zero_outputs("after reset");
      end
      @(posedge CLK); #1;
    end
    drive_start(tc.inst, 1'b0);
  endtask

  initial begin
    cases[0] = '{0, 16'h0000, 16'h0000, -5, -5, -5, 4, 29, 1};
    cases[1] = '{1, 16'h0000, 16'h0000, -5, -5, -5, 2, 15, 1};
    cases[2] = '{2, 16'h0000, 16'h0100, -5, -5, -5, 2, 19, 1};
    cases[3] = '{0, 16'h0000, 16'h0000,  3, 10, -5, 4, 29, 1};
    cases[4] = '{0, 16'h0000, 16'h0000, -5, -5, 13, 1,  0, 0};
    cases[5] = '{0, 16'h0000, 16'h0000, -5, -5, -5, 4, 29, 1};
    cases[6] = '{2, 16'hFFFE, 16'h0100, -5, -5, -5, 2, 19, 1};

    wexp[0]  = '{0,  7, 16'h0000, 64'd5};
    wexp[1]  = '{0, 14, 16'h0001, 64'd7};
    wexp[2]  = '{0, 21, 16'h0002, 64'd13};
    wexp[3]  = '{0, 28, 16'h0003, 64'd15};
    wexp[4]  = '{1,  7, 16'h0000, 64'd6};
    wexp[5]  = '{1, 14, 16'h0001, 64'd8};
    wexp[6]  = '{2,  9, 16'h0100, 64'd5};
    wexp[7]  = '{2, 18, 16'h0101, 64'd7};
    wexp[8]  = '{3,  7, 16'h0000, 64'd5};
    wexp[9]  = '{3, 14, 16'h0001, 64'd7};
    wexp[10] = '{3, 21, 16'h0002, 64'd13};
    wexp[11] = '{3, 28, 16'h0003, 64'd15};
    wexp[12] = '{4,  7, 16'h0000, 64'd5};
    wexp[13] = '{5,  7, 16'h0000, 64'd5};
    wexp[14] = '{5, 14, 16'h0001, 64'd7};
    wexp[15] = '{5, 21, 16'h0002, 64'd13};
    wexp[16] = '{5, 28, 16'h0003, 64'd15};
    wexp[17] = '{6,  9, 16'h0100, 64'h0000_0000_0000_FFFF};
    wexp[18] = '{6, 18, 16'h0101, 64'd5};

    rexp[0] = '{1, 0, 16'h0000};
    rexp[1] = '{1, 1, 16'h0001};
    rexp[2] = '{1, 2, 16'h0005};
    rexp[3] = '{1, 3, 16'h0006};
    rexp[4] = '{6, 0, 16'hFFFE};
    rexp[5] = '{6, 1, 16'hFFFF};
    rexp[6] = '{6, 2, 16'h0002};
    rexp[7] = '{6, 3, 16'h0003};

    rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 7; i++) begin
      int wi;
      run(cases[i]);
      chk($sformatf("tc%0d write count", i), 256'(wr_log.size()), 256'(cases[i].nwr));
      chk($sformatf("tc%0d done count", i), 256'(done_n), 256'(cases[i].ndone));
      chk($sformatf("tc%0d rd/wr overlap", i), 256'(overlap), '0);
      if (cases[i].ndone > 0) begin
        chk($sformatf("tc%0d done cycle", i), 256'(done_cyc), 256'(cases[i].done_cyc));
        chk($sformatf("tc%0d busy at done", i), 256'(done_busy), '0);
      end
      wi = 0;
      for (int j = 0; j < 19; j++) begin
        if (wexp[j].tc == i && wi < wr_log.size()) begin
          chk($sformatf("tc%0d wr%0d cycle", i, wi), 256'(wr_log[wi].cyc), 256'(wexp[j].cyc));
          chk($sformatf("tc%0d wr%0d addr", i, wi), 256'(wr_log[wi].addr), 256'(wexp[j].addr));
          chk($sformatf("tc%0d wr%0d data", i, wi), 256'(wr_log[wi].data), 256'(wexp[j].data));
          wi++;
        end
      end
      for (int j = 0; j < 8; j++) begin
        if (rexp[j].tc == i) begin
          if (rexp[j].idx < rd_log.size())
            chk($sformatf("tc%0d rd%0d addr", i, rexp[j].idx),
                256'(rd_log[rexp[j].idx]), 256'(rexp[j].addr));
          else
            chk($sformatf("tc%0d rd%0d present", i, rexp[j].idx), 256'(rd_log.size()),
                256'(rexp[j].idx + 1));
        end
      end
      if (cases[i].inst == 1) chk($sformatf("tc%0d dropped row/col read", i), 256'(viol), '0);
      // Last window (addresses 10,11,14,15) must persist on PATCH after DONE.
      if (i == 0) chk("tc0 PATCH held", m_patch, {64'd15, 64'd14, 64'd11, 64'd10});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
